shift_add_datapath: RTL and testbench



---
 rtl/shift_add_datapath_pkg.sv | 5 +
 rtl/shift_add_datapath_en_reg.sv | 17 +
 rtl/shift_add_datapath_step_counter.sv | 26 ++
 rtl/shift_add_datapath.sv | 48 ++++
 tb/tb_shift_add_datapath.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_datapath_pkg.sv
// Shared sizing for the shift-add multiplier and its controller wiring.
package shift_add_datapath_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CW_DEF    = $clog2(WIDTH_DEF + 1);
endpackage

// File: rtl/shift_add_datapath_en_reg.sv
// Parameterized register with synchronous clear (priority) and load enable.
module en_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (en_i)  q_o <= d_i;
  end
endmodule

// File: rtl/shift_add_datapath_step_counter.sv
// Step counter: sync clear, enable, saturates at WIDTH, terminal count flag.
module step_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                             cnt_d = '0;
    else if (en_i && cnt_q != CW'(WIDTH))  cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CW'(WIDTH));
endmodule

// File: rtl/shift_add_datapath.sv
// Iterative unsigned shift-add multiplier: one partial product per sel cycle.
module shift_add_datapath
  import shift_add_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               sel,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] d_q, d_d, p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               step;

  // Once the counter saturates, the datapath freezes so the result stays put.
  assign step = sel & ~ld & ~done;

  always_comb begin
    d_d = ld ? {{WIDTH{1'b0}}, a_in} : (d_q << 1);
    m_d = ld ? b_in : (m_q >> 1);
    p_d = p_q + (m_q[0] ? d_q : '0);
  end

  en_reg #(.W(2*WIDTH)) u_d (
    .clk(clk), .rst(rst), .clr_i(1'b0), .en_i(ld | step), .d_i(d_d), .q_o(d_q)
  );

  en_reg #(.W(WIDTH)) u_m (
    .clk(clk), .rst(rst), .clr_i(1'b0), .en_i(ld | step), .d_i(m_d), .q_o(m_q)
  );

  en_reg #(.W(2*WIDTH)) u_p (
    .clk(clk), .rst(rst), .clr_i(ld), .en_i(step), .d_i(p_d), .q_o(p_q)
  );

  step_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk(clk), .rst(rst), .clr_i(ld), .en_i(sel), .done_o(done)
  );

  assign product = p_q;
endmodule

// File: tb/tb_shift_add_datapath.sv
// Scoreboard bench for shift_add_datapath: expected products queued at load.
module tb_shift_add_datapath;
  logic        clk = 1'b0;
  logic        rst, ld, sel;
  logic [7:0]  a_in, b_in;
  logic [15:0] product;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  shift_add_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ld(ld), .sel(sel),
    .a_in(a_in), .b_in(b_in), .product(product), .done(done)
  );

  always #5 clk = ~clk;

  // Drive one cycle from a negedge; returns at the next negedge.
  task automatic cyc(input logic l, input logic s, input logic [7:0] a, input logic [7:0] b);
    ld = l; sel = s; a_in = a; b_in = b;
    if (l) begin
      exp_q = {};
      exp_q.push_back(16'(a) * 16'(b));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 8'd13, 8'd11);
    repeat (3) cyc(1'b0, 1'b1, 8'd0, 8'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (product !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: product=%0d done=%b, want 0/0", product, done);
    end
    exp_q = {};
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 8'd0);
      checks++;
      if (product !== 16'd0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: product=%0d done=%b, want 0/0", i, product, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    cyc(1'b1, 1'b0, 8'd13, 8'd11);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      checks++;
      if (done !== (i == 8)) begin
        errors++;
        $display("FAIL basic_done[%0d]: done=%b, want %b", i, done, (i == 8));
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL basic_product: scoreboard empty, product=%0d", product);
    end else begin
      exp = exp_q.pop_front();
      if (product !== exp || exp !== 16'd143) begin
        errors++;
        $display("FAIL basic_product: product=%0d, want %0d", product, exp);
      end
    end
  endtask

  task automatic test_pauses();
    logic        pat [11] = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1};
    int          q = 0;
    logic [15:0] prev;
    logic [15:0] exp;
    cyc(1'b1, 1'b0, 8'd255, 8'd255);
    for (int i = 0; i < 11; i++) begin
      prev = product;
      cyc(1'b0, pat[i], 8'd0, 8'd0);
      if (pat[i]) q++;
      checks++;
      if (done !== (q == 8)) begin
        errors++;
        $display("FAIL pause_done[%0d]: done=%b, want %b", i, done, (q == 8));
      end
      if (!pat[i]) begin
        checks++;
        if (product !== prev) begin
          errors++;
          $display("FAIL pause_hold[%0d]: product=%0d, want %0d", i, product, prev);
        end
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL pause_product: scoreboard empty, product=%0d", product);
    end else begin
      exp = exp_q.pop_front();
      if (product !== exp || exp !== 16'd65025) begin
        errors++;
        $display("FAIL pause_product: product=%0d, want %0d", product, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] exp = 16'hxxxx;
    cyc(1'b1, 1'b0, 8'd3, 8'd5);
    repeat (8) cyc(1'b0, 1'b1, 8'd0, 8'd0);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL hold_pop: scoreboard empty, product=%0d", product);
    end else begin
      exp = exp_q.pop_front();
      if (done !== 1'b1 || product !== exp) begin
        errors++;
        $display("FAIL hold_first: product=%0d done=%b, want %0d/1", product, done, exp);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      checks++;
      if (done !== 1'b1 || product !== 16'd15) begin
        errors++;
        $display("FAIL hold[%0d]: product=%0d done=%b, want 15/1", i, product, done);
      end
    end
  endtask

  task automatic test_restart();
    logic [15:0] exp;
    cyc(1'b1, 1'b0, 8'd100, 8'd7);
    repeat (4) cyc(1'b0, 1'b1, 8'd0, 8'd0);
    cyc(1'b1, 1'b1, 8'd9, 8'd9);
    checks++;
    if (product !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_load: product=%0d done=%b, want 0/0", product, done);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      checks++;
      if (done !== (i == 8)) begin
        errors++;
        $display("FAIL restart_done[%0d]: done=%b, want %b", i, done, (i == 8));
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL restart_product: scoreboard empty, product=%0d", product);
    end else begin
      exp = exp_q.pop_front();
      if (product !== exp || exp !== 16'd81) begin
        errors++;
        $display("FAIL restart_product: product=%0d, want %0d", product, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    cyc(1'b1, 1'b0, 8'd200, 8'd3);
    repeat (5) cyc(1'b0, 1'b1, 8'd0, 8'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (product !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: product=%0d done=%b, want 0/0", product, done);
    end
    exp_q = {};
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'd200, 8'd3);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      checks++;
      if (done !== (i == 8)) begin
        errors++;
        $display("FAIL reset_mid_done[%0d]: done=%b, want %b", i, done, (i == 8));
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL reset_mid_product: scoreboard empty, product=%0d", product);
    end else begin
      exp = exp_q.pop_front();
      if (product !== exp || exp !== 16'd600) begin
        errors++;
        $display("FAIL reset_mid_product: product=%0d, want %0d", product, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; sel = 1'b0; a_in = '0; b_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_pauses();
    test_hold();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
